dispatch_router: RTL and testbench

Parametrised N-wide, M-channel in-order dispatch stage that sits between rename and the reservation stations (ALU/LSU/BRU, or more).
- Routes each renamed instruction to the station selected by its pre-decoded class.
- Tracks free entries in every station with credit counters.
- Dispatches only the oldest prefix of a group that fits; the remainder waits in a holding buffer.
- Outputs are registered, so station write ports see a clean one-cycle interface.

---
 rtl/dispatch_router.sv | 183 ++++++++++++++++++
 tb/tb_dispatch_router.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dispatch_router.sv
// In-order N-wide dispatch into NUM_CH credit-tracked reservation stations.
// The oldest fitting prefix goes out through registered per-channel write lanes; the rest waits in a holding buffer.
module dispatch_router_ch #(
  parameter int DW       = 2,
  parameter int RS_DEPTH = 16,
  parameter int INSTR_W  = 64,
  parameter int CNT_W    = 5,
  parameter int UW       = 2
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [UW-1:0]                 take,
  input  logic [CNT_W-1:0]              rel,
  input  logic [DW-1:0]                 nxt_vld,
  input  logic [DW-1:0][INSTR_W-1:0]    nxt_ins,
  output logic [CNT_W-1:0]              credit,
  output logic [DW-1:0]                 out_vld,
  output logic [DW-1:0][INSTR_W-1:0]    out_ins
);
  localparam int SW = CNT_W + UW + 1;

  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] credit_nxt;

  // take never exceeds credit, so the sum cannot go negative
  assign sum        = SW'(credit) - SW'(take) + SW'(rel);
  assign credit_nxt = (sum > SW'(RS_DEPTH)) ? CNT_W'(RS_DEPTH) : sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit  <= CNT_W'(RS_DEPTH);
      out_vld <= '0;
      out_ins <= '0;
    end else if (flush) begin
      credit  <= CNT_W'(RS_DEPTH);
      out_vld <= '0;
      out_ins <= '0;
    end else begin
      credit  <= credit_nxt;
      out_vld <= nxt_vld;
      out_ins <= nxt_ins;
    end
  end
endmodule

module dispatch_router #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int NUM_CH         = 3,
  parameter int RS_DEPTH       = 16,
  parameter int INSTR_W        = 64,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W         = $clog2(RS_DEPTH + 1)
)(
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic                                        stall_dispatch,
  input  logic [DISPATCH_WIDTH-1:0]                   in_valid,
  input  logic [DISPATCH_WIDTH*INSTR_W-1:0]           in_instr,
  input  logic [DISPATCH_WIDTH*CH_W-1:0]              in_class,
  output logic                                        in_ready,
  input  logic [NUM_CH*CNT_W-1:0]                     rs_release,
  output logic [NUM_CH*DISPATCH_WIDTH-1:0]            out_valid,
  output logic [NUM_CH*DISPATCH_WIDTH*INSTR_W-1:0]    out_instr,
  output logic [NUM_CH*CNT_W-1:0]                     credit
);
  localparam int DW  = DISPATCH_WIDTH;
  localparam int UW  = $clog2(DW + 1);
  localparam int CW2 = CNT_W + UW;

  logic [DW-1:0]                      buf_vld, nb_vld, cand_vld, disp, pend;
  logic [DW-1:0][INSTR_W-1:0]         buf_ins, nb_ins, in_ins_a, cand_ins;
  logic [DW-1:0][CH_W-1:0]            buf_cls, nb_cls, in_cls_a, cand_cls;
  logic [NUM_CH-1:0][CNT_W-1:0]       cred_a, rel_a;
  logic [NUM_CH-1:0][UW-1:0]          used;
  logic [NUM_CH-1:0][DW-1:0]          nxt_vld;
  logic [NUM_CH-1:0][DW-1:0][INSTR_W-1:0] nxt_ins;
  logic                               active, blocked, buf_empty;
  logic [UW-1:0]                      pos;

  assign in_ins_a  = in_instr;
  assign in_cls_a  = in_class;
  assign rel_a     = rs_release;
  assign cred_a    = credit;
  assign buf_empty = ~|buf_vld;
  assign in_ready  = buf_empty;
  assign active    = !flush && !stall_dispatch;

  assign cand_vld = buf_empty ? in_valid : buf_vld;
  assign cand_ins = buf_empty ? in_ins_a : buf_ins;
  assign cand_cls = buf_empty ? in_cls_a : buf_cls;

  // Oldest-first scan; the first slot short of credit blocks everything younger
  always_comb begin
    blocked = 1'b0;
    used    = '0;
    disp    = '0;
    nxt_vld = '0;
    nxt_ins = '0;
    if (active) begin
      for (int i = 0; i < DW; i++) begin
        if (cand_vld[i] && !blocked) begin
          if ({1'b0, cand_cls[i]} >= (CH_W+1)'(NUM_CH)) begin
            disp[i] = 1'b1;
          end else begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (cand_cls[i] == CH_W'(c)) begin
                if (CW2'(cred_a[c]) > CW2'(used[c])) begin
                  disp[i] = 1'b1;
                  for (int l = 0; l < DW; l++) begin
                    if (used[c] == UW'(l)) begin
                      nxt_vld[c][l] = 1'b1;
                      nxt_ins[c][l] = cand_ins[i];
                    end
                  end
                  used[c] = used[c] + 1'b1;
                end else begin
                  blocked = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  assign pend = cand_vld & ~disp;

  // Leftovers (or a whole stalled group) pack down to slot 0 in order
  always_comb begin
    pos    = '0;
    nb_vld = '0;
    nb_ins = '0;
    nb_cls = '0;
    for (int i = 0; i < DW; i++) begin
      if (pend[i]) begin
        for (int j = 0; j < DW; j++) begin
          if (pos == UW'(j)) begin
            nb_vld[j] = 1'b1;
            nb_ins[j] = cand_ins[i];
            nb_cls[j] = cand_cls[i];
          end
        end
        pos = pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld <= '0;
      buf_ins <= '0;
      buf_cls <= '0;
    end else if (flush) begin
      buf_vld <= '0;
      buf_ins <= '0;
      buf_cls <= '0;
    end else begin
      buf_vld <= nb_vld;
      buf_ins <= nb_ins;
      buf_cls <= nb_cls;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dispatch_router_ch #(
      .DW(DW), .RS_DEPTH(RS_DEPTH), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .UW(UW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .take    (used[c]),
      .rel     (rel_a[c]),
      .nxt_vld (nxt_vld[c]),
      .nxt_ins (nxt_ins[c]),
      .credit  (credit[c*CNT_W +: CNT_W]),
      .out_vld (out_valid[c*DW +: DW]),
      .out_ins (out_instr[c*DW*INSTR_W +: DW*INSTR_W])
    );
  end
endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: directed vector table, async reset sequence, then random traffic vs a queue model.
module tb_dispatch_router;
  localparam int DW = 2, NCH = 3, RS = 4, IW = 16, CHW = 2, CNTW = 3;

  logic                  clk = 1'b0, rst = 1'b1, flush = 1'b0, stall = 1'b0;
  logic [DW-1:0]         in_valid = '0;
  logic [DW*IW-1:0]      in_instr = '0;
  logic [DW*CHW-1:0]     in_class = '0;
  logic                  in_ready;
  logic [NCH*CNTW-1:0]   rs_release = '0;
  logic [NCH*DW-1:0]     out_valid;
  logic [NCH*DW*IW-1:0]  out_instr;
  logic [NCH*CNTW-1:0]   credit;

  dispatch_router #(.DISPATCH_WIDTH(DW), .NUM_CH(NCH), .RS_DEPTH(RS), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_dispatch(stall),
    .in_valid(in_valid), .in_instr(in_instr), .in_class(in_class), .in_ready(in_ready),
    .rs_release(rs_release), .out_valid(out_valid), .out_instr(out_instr), .credit(credit)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct { logic [IW-1:0] ins; int cls; } item_t;
  item_t                 mq[$];
  int                    mcred[NCH];
  logic [NCH*DW-1:0]     m_ov;
  logic [NCH*DW*IW-1:0]  m_oi;

  task automatic model_reset();
    mq.delete();
    for (int c = 0; c < NCH; c++) mcred[c] = RS;
    m_ov = '0;
    m_oi = '0;
  endtask

  // One clock of the architectural behaviour, computed from the current inputs
  task automatic model_step(input logic st, input logic fl, input logic [DW-1:0] v,
                            input logic [DW*IW-1:0] ins, input logic [DW*CHW-1:0] cls,
                            input logic [NCH*CNTW-1:0] rel);
    item_t cand[$];
    int lane[NCH];
    int k, c, n;
    m_ov = '0;
    m_oi = '0;
    if (fl) begin
      mq.delete();
      for (int x = 0; x < NCH; x++) mcred[x] = RS;
      return;
    end
    if (mq.size() > 0) cand = mq;
    else
      for (int s = 0; s < DW; s++)
        if (v[s]) cand.push_back('{ins[s*IW +: IW], int'(cls[s*CHW +: CHW])});
    for (int x = 0; x < NCH; x++) lane[x] = 0;
    k = 0;
    if (!st) begin
      while (k < cand.size()) begin
        c = cand[k].cls;
        if (c >= NCH) k++;
        else if (mcred[c] - lane[c] > 0) begin
          m_ov[c*DW + lane[c]] = 1'b1;
          m_oi[(c*DW + lane[c])*IW +: IW] = cand[k].ins;
          lane[c]++;
          k++;
        end else break;
      end
    end
    mq.delete();
    for (int j = k; j < cand.size(); j++) mq.push_back(cand[j]);
    for (int x = 0; x < NCH; x++) begin
      n = mcred[x] - lane[x] + int'(rel[x*CNTW +: CNTW]);
      mcred[x] = (n > RS) ? RS : n;
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NCH*CNTW-1:0] ec;
    for (int c = 0; c < NCH; c++) ec[c*CNTW +: CNTW] = CNTW'(mcred[c]);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(m_ov));
    chk({tag, ".out_instr"}, 128'(out_instr), 128'(m_oi));
    chk({tag, ".credit"},    128'(credit),    128'(ec));
    chk({tag, ".in_ready"},  128'(in_ready),  128'(mq.size() == 0));
  endtask

  task automatic drive(input logic st, input logic fl, input logic [DW-1:0] v,
                       input logic [DW*IW-1:0] ins, input logic [DW*CHW-1:0] cls,
                       input logic [NCH*CNTW-1:0] rel);
    stall = st; flush = fl; in_valid = v; in_instr = ins; in_class = cls; rs_release = rel;
    model_step(st, fl, v, ins, cls, rel);
  endtask

  typedef struct {
    logic st, fl;
    logic [1:0] v, c0, c1;
    logic [8:0] rel;
    logic [5:0] ov;
    logic [8:0] cr;
    logic rdy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [DW*IW-1:0] ins;
    // credit / release fields pack as octal {c2,c1,c0}
    tbl[0]  = '{1'b0, 1'b0, 2'b11, 2'd0, 2'd2, 9'o000, 6'b010001, 9'o343, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 2'b11, 2'd1, 2'd1, 9'o000, 6'b001100, 9'o323, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 2'b11, 2'd0, 2'd0, 9'o000, 6'b000011, 9'o321, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 2'b11, 2'd0, 2'd0, 9'o000, 6'b000001, 9'o320, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 9'o001, 6'b000000, 9'o321, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 9'o000, 6'b000001, 9'o320, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 9'o000, 6'b000000, 9'o320, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 2'b11, 2'd1, 2'd1, 9'o000, 6'b001100, 9'o300, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 2'd1, 2'd2, 9'o000, 6'b000000, 9'o300, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'b11, 2'd0, 2'd0, 9'o111, 6'b000000, 9'o444, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 9'o000, 6'b000000, 9'o444, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'b11, 2'd0, 2'd1, 9'o000, 6'b000000, 9'o444, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 2'b11, 2'd2, 2'd2, 9'o000, 6'b000000, 9'o444, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'b00, 2'd0, 2'd0, 9'o000, 6'b000000, 9'o444, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 2'b11, 2'd2, 2'd2, 9'o000, 6'b000101, 9'o433, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 2'b11, 2'd3, 2'd0, 9'o000, 6'b000001, 9'o432, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 2'b01, 2'd0, 2'd0, 9'o001, 6'b000001, 9'o432, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 9'o777, 6'b000000, 9'o444, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 2'b10, 2'd0, 2'd2, 9'o000, 6'b010000, 9'o344, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      ins = {8'(i), 8'hB1, 8'(i), 8'hB0};
      drive(tbl[i].st, tbl[i].fl, tbl[i].v, ins, {tbl[i].c1, tbl[i].c0}, tbl[i].rel);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
      chk($sformatf("vec%0d.credit", i),    128'(credit),    128'(tbl[i].cr));
      chk($sformatf("vec%0d.in_ready", i),  128'(in_ready),  128'(tbl[i].rdy));
      check_model($sformatf("vec%0d", i));
    end

    // async reset while outputs are live and the buffer is occupied
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, 32'hC0DE_C0DD, {2'd2, 2'd2}, '0);
    @(posedge clk); #1;
    check_model("rstseq.a");
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, 32'hC1DE_C1DD, {2'd2, 2'd2}, '0);
    @(posedge clk); #1;
    check_model("rstseq.b");
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_model("rstseq.async");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, '0, '0, '0);
    @(posedge clk); #1;
    check_model("rstseq.after");

    for (int n = 0; n < 600; n++) begin
      logic [NCH*CNTW-1:0] rel;
      logic [DW*CHW-1:0]   cls;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) rel[c*CNTW +: CNTW] = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0;
      for (int s = 0; s < DW; s++) cls[s*CHW +: CHW] = CHW'($urandom_range(0, 3));
      drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 31) == 0),
            DW'($urandom_range(0, 3)), DW*IW'($urandom), cls, rel);
      @(posedge clk); #1;
      check_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
